mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath: one shared memory port, one ALU, IR/MDR/A/B/ALUOut regs.
//  Sequences fetch, decode, execute, memory and writeback per instruction from the IR opcode.
//  Stalls on a memory-ready handshake and flags unsupported opcodes.
//  Sits beside the datapath; drives every mux select and write enable.
// PARAMETERS
//  CNT_W  32  width of the performance counters (MC_CTRL_PERF_EN only)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      synchronous, active-high reset
//  opcode        in   6      IR[31:26]; stable from DECODE to the end of the instruction
//  mem_ready     in   1      memory completes the current access this cycle
//  pc_write      out  1      unconditional PC load
//  pc_write_cond out  1      PC load if (zero ^ branch_ne)
//  branch_ne     out  1      1 = BNE sense
//  iord          out  1      memory address: 0 = PC, 1 = ALUOut
//  mem_read      out  1      memory read request, held until mem_ready
//  mem_write     out  1      memory write request, held until mem_ready
//  ir_write      out  1      IR load
//  reg_dst       out  1      write register: 0 = rt, 1 = rd
//  mem_to_reg    out  1      write data: 0 = ALUOut, 1 = MDR
//  reg_write     out  1      register file write enable
//  alu_src_a     out  1      0 = PC, 1 = A
//  alu_src_b     out  2      00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
//  alu_op        out  2      00 = add, 01 = sub, 10 = use funct
//  pc_source     out  2      00 = ALU result, 01 = ALUOut, 10 = jump target
//  instr_done    out  1      1-cycle pulse on the last cycle of each legal instruction
//  illegal_op    out  1      1-cycle pulse in DECODE for an unsupported opcode
//  cycle_cnt     out  CNT_W  free-running cycle count
//  instret_cnt   out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Moore FSM with a 4-bit state register. Outputs decode from state, plus mem_ready where noted. Unlisted outputs are 0.
//  FETCH:   mem_read, alu_src_b=01, alu_op=00. On mem_ready: ir_write, pc_write, pc_source=00, go to DECODE. Otherwise hold.
//  DECODE:  alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
//           LW/SW->MEMADR, R(000000)->EXEC_R, BEQ/BNE->BRANCH, ADDI->ADDI_EX, J->JUMP.
//           Any other opcode: illegal_op=1, go to FETCH, no state written.
//  MEMADR:  alu_src_a=1, alu_src_b=10, alu_op=00. LW->MEMRD, SW->MEMWR.
//  MEMRD:   iord, mem_read. Hold until mem_ready, then MEMWB.
//  MEMWB:   reg_write, mem_to_reg=1, reg_dst=0, instr_done. Go to FETCH.
//  MEMWR:   iord, mem_write. Hold until mem_ready; on the mem_ready cycle instr_done=1 and go to FETCH.
//  EXEC_R:  alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
//  RWB:     reg_write, reg_dst=1, mem_to_reg=0, instr_done. Go to FETCH.
//  BRANCH:  alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01, branch_ne=(opcode==000101), instr_done. Go to FETCH.
//  ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
//  ADDI_WB: reg_write, reg_dst=0, mem_to_reg=0, instr_done. Go to FETCH.
//  JUMP:    pc_write, pc_source=10, instr_done. Go to FETCH.
//  Unused state encodings go to FETCH on the next edge. No outputs are asserted in them.
//  Latency with mem_ready tied 1: BEQ/BNE/J = 3 cycles; R/ADDI/SW = 4; LW = 5. Each memory stall cycle adds 1.
//  Reset: next edge forces FETCH and clears the counters; an in-flight memory access is abandoned.
//   While rst=1, pc_write, pc_write_cond, ir_write, reg_write, mem_write and mem_read are gated to 0.
//   Reset values: all outputs 0, except alu_src_b=01.
//  mem_ready is ignored outside FETCH/MEMRD/MEMWR. A write is performed once, on its mem_ready cycle.
// CONFIGURATION
//  MC_CTRL_PERF_EN defined:
//   cycle_cnt increments every non-reset cycle; instret_cnt increments on instr_done.
//   Both reset to 0 and wrap modulo 2^CNT_W.
//  MC_CTRL_PERF_EN undefined: cycle_cnt and instret_cnt are tied to 0; the port list is unchanged.
// STRUCTURE
//  Package mips_ctrl_pkg: opcode constants, state encodings, alu_op / alu_src_b / pc_source codes.
//  Sub-module mc_ctrl_perf_counters (both counters) is instantiated only under MC_CTRL_PERF_EN.
// TESTING
//  rst held 2 cycles, then released -> FETCH, mem_read=1 after release, counters 0, no write enable seen.
//  opcode=000000, mem_ready=1 -> FETCH/DECODE/EXEC_R/RWB; reg_write with reg_dst=1 in cycle 4; instr_done once.
//  LW (100011), mem_ready low 3 cycles in MEMRD -> iord=1, mem_read held 4 cycles, then MEMWB with mem_to_reg=1; total 8 cycles.
//  BNE (000101) -> BRANCH: pc_write_cond=1, branch_ne=1, pc_source=01; 3 cycles total.
//  opcode=111111 -> illegal_op pulse in DECODE, back to FETCH, no reg_write/mem_write; instret_cnt unchanged.
//  PERF_EN: 10 legal instructions, then rst mid-SW with mem_write high -> instret_cnt=10 before reset;
//   next edge FETCH and counters 0; mem_write drops in the reset cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control FSM: opcodes, state encodings
// and the datapath select codes it drives.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Twelve live states; encodings 12..15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_perf_counters.sv
// Free-running cycle counter and retired-instruction counter, both wrapping
// modulo 2^CNT_W and cleared by the synchronous reset.
module mc_ctrl_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [CNT_W-1:0] cycle_reg;
  logic [CNT_W-1:0] instret_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + CNT_W'(1);
      if (instr_done)
        instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_reg;
  assign instret_cnt = instret_reg;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath (Moore, memory-ready stalls).
// Performance counters are built only when MC_CTRL_PERF_EN is defined.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t state_reg, state_next;

  logic pc_write_dec, pc_write_cond_dec, ir_write_dec;
  logic reg_write_dec, mem_write_dec, mem_read_dec;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next        = state_reg;
    pc_write_dec      = 1'b0;
    pc_write_cond_dec = 1'b0;
    ir_write_dec      = 1'b0;
    reg_write_dec     = 1'b0;
    mem_write_dec     = 1'b0;
    mem_read_dec      = 1'b0;
    branch_ne         = 1'b0;
    iord              = 1'b0;
    reg_dst           = 1'b0;
    mem_to_reg        = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = SRCB_B;
    alu_op            = ALU_ADD;
    pc_source         = PCSRC_ALU;
    instr_done        = 1'b0;
    illegal_op        = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_read_dec = 1'b1;
        alu_src_b    = SRCB_FOUR;
        if (mem_ready) begin
          ir_write_dec = 1'b1;
          pc_write_dec = 1'b1;
          state_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively here and parked in ALUOut.
        alu_src_b = SRCB_IMM_SL2;
        case (opcode)
          OP_LW, OP_SW:   state_next = S_MEMADR;
          OP_RTYPE:       state_next = S_EXEC_R;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI:        state_next = S_ADDI_EX;
          OP_J:           state_next = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord         = 1'b1;
        mem_read_dec = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_dec = 1'b1;
        mem_to_reg    = 1'b1;
        instr_done    = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_dec = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        state_next = S_RWB;
      end
      S_RWB: begin
        reg_write_dec = 1'b1;
        reg_dst       = 1'b1;
        instr_done    = 1'b1;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a         = 1'b1;
        alu_op            = ALU_SUB;
        pc_write_cond_dec = 1'b1;
        pc_source         = PCSRC_ALUOUT;
        branch_ne         = (opcode == OP_BNE);
        instr_done        = 1'b1;
        state_next        = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_dec = 1'b1;
        instr_done    = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_write_dec = 1'b1;
        pc_source    = PCSRC_JUMP;
        instr_done   = 1'b1;
        state_next   = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Every state-changing strobe is killed while reset is held.
  assign pc_write      = pc_write_dec      & ~rst;
  assign pc_write_cond = pc_write_cond_dec & ~rst;
  assign ir_write      = ir_write_dec      & ~rst;
  assign reg_write     = reg_write_dec     & ~rst;
  assign mem_write     = mem_write_dec     & ~rst;
  assign mem_read      = mem_read_dec      & ~rst;

`ifdef MC_CTRL_PERF_EN
  mc_ctrl_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .instr_done  (instr_done),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: per-instruction timeline model built
// from opcode and planned stall counts, plus reset and counter scenarios.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 32;
  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_ADDI = 6'b001000, T_J = 6'b000010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = '0;
  logic mem_ready = 1'b0;
  logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int total = 0;
  int bad = 0;
  int unsigned exp_cyc = 0;
  int unsigned exp_ret = 0;
  bit perf;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  function automatic bit legal_op(input logic [5:0] op);
    return op == T_R || op == T_LW || op == T_SW || op == T_BEQ ||
           op == T_BNE || op == T_ADDI || op == T_J;
  endfunction

  function automatic logic [5:0] pick_legal();
    logic [5:0] tbl [7];
    tbl = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_J};
    return tbl[$urandom_range(0, 6)];
  endfunction

  function automatic logic [CNT_W-1:0] want_cyc();
    return perf ? CNT_W'(exp_cyc) : '0;
  endfunction

  function automatic logic [CNT_W-1:0] want_ret();
    return perf ? CNT_W'(exp_ret) : '0;
  endfunction

  // Advance one clock; inputs for the new cycle are driven 1 time unit after the edge.
  task automatic next_cycle();
    bit r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) begin exp_cyc = 0; exp_ret = 0; end
    else exp_cyc++;
  endtask

  // Runs one instruction starting in a FETCH cycle. f = fetch stall cycles,
  // m = data-memory stall cycles (LW/SW only).
  task automatic run_instr(input logic [5:0] op, input int f, input int m, input string name);
    bit is_lw, is_sw, is_r, is_addi, is_br, is_j, is_mem, legal;
    int len, mem_lo, mem_hi, regw_at;
    int done_cnt = 0, done_idx = -1, ill_cnt = 0, ill_idx = -1, irw_cnt = 0, irw_idx = -1;
    int pcw_cnt = 0, pcwc_cnt = 0, regw_cnt = 0, regw_idx = -1;
    int memw_cnt = 0, memw_rdy = 0, memr_cnt = 0, iord_cnt = 0;
    logic rd_at = 1'bx, m2r_at = 1'bx, bne_at = 1'bx;
    logic [1:0] srcb0 = 'x, srcb_dec = 'x, aluop3 = 'x, pcs_fetch = 'x, pcs_br = 'x, pcs_j = 'x;
    logic [1:0] want_aluop;
    is_lw = (op == T_LW); is_sw = (op == T_SW); is_r = (op == T_R); is_addi = (op == T_ADDI);
    is_br = (op == T_BEQ) || (op == T_BNE); is_j = (op == T_J);
    is_mem = is_lw || is_sw;
    legal = legal_op(op);
    mem_lo = f + 3;
    mem_hi = f + 3 + m;
    if (is_r || is_addi)     len = f + 4;
    else if (is_br || is_j)  len = f + 3;
    else if (is_lw)          len = f + 5 + m;
    else if (is_sw)          len = f + 4 + m;
    else                     len = f + 2;
    regw_at = is_lw ? f + 4 + m : f + 3;
    want_aluop = is_r ? 2'b10 : (is_br ? 2'b01 : 2'b00);
    opcode = op;

    total++;
    if (cycle_cnt !== want_cyc() || instret_cnt !== want_ret()) begin
      bad++;
      $display("FAIL %s counters got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
               name, cycle_cnt, instret_cnt, want_cyc(), want_ret());
    end

    for (int k = 0; k < len; k++) begin
      if (k < f)                              mem_ready = 1'b0;
      else if (k == f)                        mem_ready = 1'b1;
      else if (is_mem && k >= mem_lo && k < mem_hi) mem_ready = 1'b0;
      else if (is_mem && k == mem_hi)         mem_ready = 1'b1;
      else                                    mem_ready = 1'($urandom_range(0, 1));
      #3;
      if (instr_done) begin done_cnt++; done_idx = k; end
      if (illegal_op) begin ill_cnt++; ill_idx = k; end
      if (ir_write) begin irw_cnt++; irw_idx = k; end
      if (pc_write) pcw_cnt++;
      if (pc_write_cond) begin pcwc_cnt++; bne_at = branch_ne; pcs_br = pc_source; end
      if (reg_write) begin regw_cnt++; regw_idx = k; rd_at = reg_dst; m2r_at = mem_to_reg; end
      if (mem_write) begin memw_cnt++; if (mem_ready) memw_rdy++; end
      if (mem_read) memr_cnt++;
      if (iord) iord_cnt++;
      if (k == 0) srcb0 = alu_src_b;
      if (k == f) pcs_fetch = pc_source;
      if (k == f + 1) srcb_dec = alu_src_b;
      if (k == f + 2) aluop3 = alu_op;
      if (is_j && k == f + 2) pcs_j = pc_source;
      if (legal && k == len - 1) exp_ret++;
      next_cycle();
    end

    $display("instr %s op=%b fstall=%0d mstall=%0d cycles=%0d done=%0d illegal=%0d",
             name, op, f, m, len, done_cnt, ill_cnt);

    total++;
    if (done_cnt !== (legal ? 1 : 0) || (legal && done_idx !== len - 1)) begin
      bad++; $display("FAIL %s instr_done got cnt=%0d at=%0d want cnt=%0d at=%0d",
                      name, done_cnt, done_idx, legal ? 1 : 0, len - 1);
    end
    total++;
    if (ill_cnt !== (legal ? 0 : 1) || (!legal && ill_idx !== f + 1)) begin
      bad++; $display("FAIL %s illegal_op got cnt=%0d at=%0d want cnt=%0d at=%0d",
                      name, ill_cnt, ill_idx, legal ? 0 : 1, f + 1);
    end
    total++;
    if (irw_cnt !== 1 || irw_idx !== f) begin
      bad++; $display("FAIL %s ir_write got cnt=%0d at=%0d want cnt=1 at=%0d", name, irw_cnt, irw_idx, f);
    end
    total++;
    if (pcw_cnt !== (is_j ? 2 : 1)) begin
      bad++; $display("FAIL %s pc_write got cnt=%0d want %0d", name, pcw_cnt, is_j ? 2 : 1);
    end
    total++;
    if (pcwc_cnt !== (is_br ? 1 : 0) || (is_br && (bne_at !== (op == T_BNE) || pcs_br !== 2'b01))) begin
      bad++; $display("FAIL %s branch got cnt=%0d ne=%b pcsrc=%b want cnt=%0d ne=%b pcsrc=01",
                      name, pcwc_cnt, bne_at, pcs_br, is_br ? 1 : 0, op == T_BNE);
    end
    total++;
    if (regw_cnt !== ((is_lw || is_r || is_addi) ? 1 : 0) ||
        ((is_lw || is_r || is_addi) && (regw_idx !== regw_at || rd_at !== is_r || m2r_at !== is_lw))) begin
      bad++; $display("FAIL %s reg_write got cnt=%0d at=%0d dst=%b m2r=%b want at=%0d dst=%b m2r=%b",
                      name, regw_cnt, regw_idx, rd_at, m2r_at, regw_at, is_r, is_lw);
    end
    total++;
    if (memw_cnt !== (is_sw ? m + 1 : 0) || memw_rdy !== (is_sw ? 1 : 0)) begin
      bad++; $display("FAIL %s mem_write got cycles=%0d ready=%0d want cycles=%0d ready=%0d",
                      name, memw_cnt, memw_rdy, is_sw ? m + 1 : 0, is_sw ? 1 : 0);
    end
    total++;
    if (memr_cnt !== f + 1 + (is_lw ? m + 1 : 0) || iord_cnt !== (is_mem ? m + 1 : 0)) begin
      bad++; $display("FAIL %s mem_read/iord got rd=%0d iord=%0d want rd=%0d iord=%0d",
                      name, memr_cnt, iord_cnt, f + 1 + (is_lw ? m + 1 : 0), is_mem ? m + 1 : 0);
    end
    total++;
    if (srcb0 !== 2'b01 || srcb_dec !== 2'b11 || pcs_fetch !== 2'b00) begin
      bad++; $display("FAIL %s fetch/decode got srcb=%b/%b pcsrc=%b want 01/11 00",
                      name, srcb0, srcb_dec, pcs_fetch);
    end
    if (legal) begin
      total++;
      if (aluop3 !== want_aluop || (is_j && pcs_j !== 2'b10)) begin
        bad++; $display("FAIL %s exec got alu_op=%b jpcsrc=%b want alu_op=%b", name, aluop3, pcs_j, want_aluop);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    #3;
    total++;
    if ({pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read, iord, instr_done,
         illegal_op, alu_op, pc_source, alu_src_b} !== 15'b000000000_00_00_01 ||
        cycle_cnt !== '0 || instret_cnt !== '0) begin
      bad++; $display("FAIL reset_hold got pcw=%b irw=%b rw=%b mw=%b mr=%b srcb=%b cyc=%0d ret=%0d want all 0 srcb=01",
                      pc_write, ir_write, reg_write, mem_write, mem_read, alu_src_b, cycle_cnt, instret_cnt);
    end
    next_cycle();
    rst = 1'b0;
    #3;
    total++;
    if (mem_read !== 1'b1 || alu_src_b !== 2'b01 || cycle_cnt !== '0 || instret_cnt !== '0 ||
        reg_write !== 1'b0 || mem_write !== 1'b0) begin
      bad++; $display("FAIL reset_release got mr=%b srcb=%b cyc=%0d ret=%0d want mr=1 srcb=01 counters 0",
                      mem_read, alu_src_b, cycle_cnt, instret_cnt);
    end
    $display("instr reset released");
    #(-0);
  endtask

  task automatic test_rtype();
    run_instr(T_R, 0, 0, "rtype");
    run_instr(T_ADDI, 1, 0, "addi_fstall");
  endtask

  task automatic test_lw_stall();
    run_instr(T_LW, 0, 3, "lw_stall3");
    run_instr(T_SW, 0, 2, "sw_stall2");
  endtask

  task automatic test_branch();
    run_instr(T_BNE, 0, 0, "bne");
    run_instr(T_BEQ, 0, 0, "beq");
    run_instr(T_J, 0, 0, "jump");
  endtask

  task automatic test_illegal();
    int unsigned ret_before;
    ret_before = exp_ret;
    run_instr(6'b111111, 0, 0, "illegal");
    total++;
    if (instret_cnt !== (perf ? CNT_W'(ret_before) : '0)) begin
      bad++; $display("FAIL illegal_instret got %0d want %0d", instret_cnt, perf ? ret_before : 0);
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (legal_op(op)) op = 6'($urandom_range(0, 63));
      end else op = pick_legal();
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid_sw();
    for (int i = 0; i < 10; i++)
      run_instr(pick_legal(), $urandom_range(0, 1), $urandom_range(0, 2), "pre_sw");
    opcode = T_SW;
    mem_ready = 1'b1;
    next_cycle();            // DECODE
    mem_ready = 1'b0;
    next_cycle();            // MEMADR
    next_cycle();            // MEMWR, stalled
    #3;
    total++;
    if (mem_write !== 1'b1 || iord !== 1'b1 || instret_cnt !== (perf ? CNT_W'(10) : '0)) begin
      bad++; $display("FAIL mid_sw got mw=%b iord=%b ret=%0d want mw=1 iord=1 ret=%0d",
                      mem_write, iord, instret_cnt, perf ? 10 : 0);
    end
    next_cycle();            // still MEMWR, now under reset
    rst = 1'b1;
    #3;
    total++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      bad++; $display("FAIL sw_reset_gate got mw=%b mr=%b want 0 0", mem_write, mem_read);
    end
    next_cycle();
    rst = 1'b0;
    #3;
    total++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || alu_src_b !== 2'b01 ||
        cycle_cnt !== '0 || instret_cnt !== '0) begin
      bad++; $display("FAIL sw_reset_after got mr=%b mw=%b srcb=%b cyc=%0d ret=%0d want 1 0 01 0 0",
                      mem_read, mem_write, alu_src_b, cycle_cnt, instret_cnt);
    end
    $display("instr reset during sw store");
    run_instr(T_R, 0, 0, "after_reset");
  endtask

  initial begin
`ifdef MC_CTRL_PERF_EN
    perf = 1'b1;
`else
    perf = 1'b0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_illegal();
    test_random();
    test_reset();
    test_reset_mid_sw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
